// File: rtl/fir_mac_engine_if.sv
// -----------------------------------------------------------------------------
// fir_mac_engine_if
//
// Groups the sample input stream, the coefficient write port and the result
// output stream of fir_mac_engine into one bundle.
//
// Parameters (must match the engine instance):
//   INW   - sample and coefficient width (signed)
//   OUTW  - result width (signed)
//   TAPS  - taps per channel, sizes coef_addr
//   CHANS - channel count, sizes in_chan / out_chan (minimum 1 bit)
//
// Signals:
//   in_valid / in_ready / in_chan / in_data    sample stream into the engine
//   coef_we / coef_addr / coef_data            coefficient write port
//   out_valid / out_ready / out_chan / out_data result stream out of the engine
//
// Modports:
//   master - the side that feeds samples and coefficients and consumes results
//   slave  - the engine itself
// -----------------------------------------------------------------------------
interface fir_mac_engine_if #(
    parameter int INW   = 16,
    parameter int OUTW  = 38,
    parameter int TAPS  = 64,
    parameter int CHANS = 4
);
    localparam int AW = $clog2(TAPS);
    localparam int CW = (CHANS > 1) ? $clog2(CHANS) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [CW-1:0]          in_chan;
    logic signed [INW-1:0]  in_data;

    logic                   coef_we;
    logic [AW-1:0]          coef_addr;
    logic signed [INW-1:0]  coef_data;

    logic                   out_valid;
    logic                   out_ready;
    logic [CW-1:0]          out_chan;
    logic signed [OUTW-1:0] out_data;

    modport master (
        output in_valid, in_chan, in_data,
        output coef_we, coef_addr, coef_data,
        output out_ready,
        input  in_ready, out_valid, out_chan, out_data
    );

    modport slave (
        input  in_valid, in_chan, in_data,
        input  coef_we, coef_addr, coef_data,
        input  out_ready,
        output in_ready, out_valid, out_chan, out_data
    );
endinterface

// File: rtl/fir_mac_engine.sv
// -----------------------------------------------------------------------------
// fir_mac_engine
//
// Time-multiplexed multi-channel FIR filter built around one signed
// multiply-accumulate unit. A sample arrives on a valid/ready handshake with a
// channel tag, is written into that channel's circular history buffer, and the
// full convolution y[n] = sum h[k] * x[n-k] is then run serially, one tap per
// clock. The scaled result is presented on a valid/ready output and held until
// taken. Coefficients are run-time programmable and shared by all channels.
//
// Parameters:
//   INW   - sample/coefficient width (signed)
//   OUTW  - result width (signed)
//   TAPS  - taps per channel (>= 2, need not be a power of two)
//   CHANS - number of independent channels (>= 1)
//   SHIFT - arithmetic right shift applied to the accumulator on output
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high, clears all state
//   bus   - fir_mac_engine_if.slave: sample in, coefficient write, result out
//
// Build option:
//   FIR_SAT_EN - when defined, the scaled result is saturated to the OUTW range;
//                otherwise the low OUTW bits are taken (wrap-around).
// -----------------------------------------------------------------------------
module fir_mac_engine #(
    parameter int INW   = 16,
    parameter int OUTW  = 38,
    parameter int TAPS  = 64,
    parameter int CHANS = 4,
    parameter int SHIFT = 0
) (
    input  logic              clock,
    input  logic              reset,
    fir_mac_engine_if.slave   bus
);
    localparam int AW   = $clog2(TAPS);
    localparam int CW   = (CHANS > 1) ? $clog2(CHANS) : 1;
    localparam int PW   = 2 * INW;
    localparam int ACCW = PW + AW;
    localparam int WW   = (ACCW > OUTW) ? ACCW : OUTW;

    localparam logic [AW-1:0] LAST_TAP   = AW'(TAPS - 1);
    localparam logic [AW-1:0] ONE_TAP    = AW'(1);
    localparam logic [AW:0]   TAPS_LIMIT = (AW + 1)'(TAPS);
    localparam logic [CW:0]   CHAN_LIMIT = (CW + 1)'(CHANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                 state;

    logic signed [INW-1:0]  hist_mem [CHANS][TAPS];
    logic signed [INW-1:0]  coef_mem [TAPS];
    logic [AW-1:0]          wptr     [CHANS];

    logic [AW-1:0]          tap;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          rd_chan;
    logic [CW-1:0]          chan_q;
    logic signed [ACCW-1:0] acc;

    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [CW-1:0]          out_chan_q;
    logic signed [OUTW-1:0] out_data_q;

    logic                   chan_ok;
    logic                   coef_addr_ok;
    logic [CW-1:0]          sel_chan;
    logic [AW-1:0]          cur_ptr;
    logic [AW-1:0]          adv_ptr;
    logic signed [PW-1:0]   coef_ext;
    logic signed [PW-1:0]   samp_ext;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] scaled;
    logic signed [WW-1:0]   wide;
    logic signed [OUTW-1:0] out_next;
`ifdef FIR_SAT_EN
    logic                   fits;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_data  = out_data_q;

    // Accept-side address arithmetic. Out-of-range channel tags are redirected
    // to channel 0 for reading, and the sample itself is never stored. Range
    // checks compare against a one-bit-wider limit so they stay meaningful
    // when the field width exactly covers the count.
    always_comb begin
        chan_ok      = ({1'b0, bus.in_chan} < CHAN_LIMIT);
        coef_addr_ok = ({1'b0, bus.coef_addr} < TAPS_LIMIT);
        sel_chan     = chan_ok ? bus.in_chan : '0;
        cur_ptr      = wptr[sel_chan];
        adv_ptr      = (cur_ptr == LAST_TAP) ? '0 : cur_ptr + ONE_TAP;
    end

    // One multiply-accumulate step plus output scaling. The product is
    // sign-extended by clog2(TAPS) bits so the running sum cannot overflow.
    always_comb begin
        coef_ext = PW'(coef_mem[tap]);
        samp_ext = PW'(hist_mem[rd_chan][rd_ptr]);
        prod     = coef_ext * samp_ext;
        acc_next = acc + {{AW{prod[PW-1]}}, prod};
        scaled   = acc_next >>> SHIFT;
        wide     = WW'(scaled);
`ifdef FIR_SAT_EN
        fits     = (wide[WW-1:OUTW-1] == {(WW - OUTW + 1){wide[WW-1]}});
        if (fits) begin
            out_next = wide[OUTW-1:0];
        end else if (wide[WW-1]) begin
            out_next = {1'b1, {(OUTW - 1){1'b0}}};
        end else begin
            out_next = {1'b0, {(OUTW - 1){1'b1}}};
        end
`else
        out_next = OUTW'(wide);
`endif
    end

    // Control FSM and all datapath state. In IDLE the engine takes coefficient
    // writes and one sample; MAC walks taps 0..TAPS-1 while the read pointer
    // walks backwards through the channel's history (wrapping from 0 to
    // TAPS-1 explicitly, so any TAPS works); OUT holds the registered result
    // until the consumer takes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tap         <= '0;
            rd_ptr      <= '0;
            rd_chan     <= '0;
            chan_q      <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            for (int k = 0; k < TAPS; k++) begin
                coef_mem[k] <= '0;
            end
            for (int c = 0; c < CHANS; c++) begin
                wptr[c] <= '0;
                for (int k = 0; k < TAPS; k++) begin
                    hist_mem[c][k] <= '0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.coef_we && coef_addr_ok) begin
                        coef_mem[bus.coef_addr] <= bus.coef_data;
                    end
                    if (bus.in_valid) begin
                        if (chan_ok) begin
                            hist_mem[sel_chan][adv_ptr] <= bus.in_data;
                            wptr[sel_chan]              <= adv_ptr;
                            rd_ptr                      <= adv_ptr;
                        end else begin
                            rd_ptr <= cur_ptr;
                        end
                        rd_chan    <= sel_chan;
                        chan_q     <= bus.in_chan;
                        acc        <= '0;
                        tap        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= S_MAC;
                    end
                end

                S_MAC: begin
                    acc    <= acc_next;
                    rd_ptr <= (rd_ptr == '0) ? LAST_TAP : rd_ptr - ONE_TAP;
                    if (tap == LAST_TAP) begin
                        out_data_q  <= out_next;
                        out_chan_q  <= chan_q;
                        out_valid_q <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        tap <= tap + ONE_TAP;
                    end
                end

                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_engine.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_engine
//
// Self-checking bench for fir_mac_engine, built with a small non-power-of-two
// tap count, a non-power-of-two channel count (so out-of-range tags exist),
// a narrow output and a one-bit shift so that floor rounding and the
// wrap/saturate choice (FIR_SAT_EN) both matter.
//
// The reference model keeps, per channel, a sliding window of the most recent
// TAPS samples (newest first) and computes the dot product with the
// coefficient array directly.
// -----------------------------------------------------------------------------
module tb_fir_mac_engine;
    localparam int INW   = 16;
    localparam int OUTW  = 24;
    localparam int TAPS  = 5;
    localparam int CHANS = 3;
    localparam int SHIFT = 1;
    localparam int CW    = 2;
    localparam int AW    = 3;

    typedef struct {
        int     chan;
        longint data;
        int     exp_chan;
        longint exp_data;
    } vec_t;

    logic clock = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    longint m_coef [TAPS];
    longint m_win  [CHANS][TAPS];

    always #5 clock = ~clock;

    fir_mac_engine_if #(.INW(INW), .OUTW(OUTW), .TAPS(TAPS), .CHANS(CHANS)) bus ();

    fir_mac_engine #(
        .INW(INW), .OUTW(OUTW), .TAPS(TAPS), .CHANS(CHANS), .SHIFT(SHIFT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Comparison bookkeeping shared by every check in the bench.
    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < TAPS; k++) begin
            m_coef[k] = 0;
            for (int c = 0; c < CHANS; c++) begin
                m_win[c][k] = 0;
            end
        end
    endtask

    // Floor shift, then either clamp to the output range or keep the low OUTW
    // bits reinterpreted as signed.
    function automatic longint model_scale(input longint acc);
        longint s;
        longint lim;
        s   = acc >>> SHIFT;
        lim = 64'sd1 <<< (OUTW - 1);
`ifdef FIR_SAT_EN
        if (s > lim - 1) s = lim - 1;
        if (s < -lim)    s = -lim;
`else
        s = s & ((lim <<< 1) - 1);
        if (s >= lim) s = s - (lim <<< 1);
`endif
        return s;
    endfunction

    // A sample on a valid channel shifts into that channel's window; an
    // out-of-range tag is dropped and channel 0's window is used instead.
    function automatic longint model_accept(input int chan, input longint data);
        int     src;
        longint acc;
        if (chan < CHANS) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                m_win[chan][k] = m_win[chan][k-1];
            end
            m_win[chan][0] = data;
        end
        src = (chan < CHANS) ? chan : 0;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            acc += m_coef[k] * m_win[src][k];
        end
        return model_scale(acc);
    endfunction

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) check("in_ready timeout", 0, 1);
    endtask

    task automatic write_coef(input int k, input longint v);
        wait_ready();
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(k);
        bus.coef_data = INW'(v);
        @(negedge clock);
        bus.coef_we   = 1'b0;
        m_coef[k]     = v;
    endtask

    task automatic set_ramp_coefs();
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    endtask

    task automatic set_flat_coefs(input longint v);
        for (int k = 0; k < TAPS; k++) write_coef(k, v);
    endtask

    // Offers one sample and returns the model's expected result for it.
    task automatic applyStimulus(input int chan, input longint data, output longint exp);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_chan  = CW'(chan);
        bus.in_data  = INW'(data);
        @(negedge clock);
        bus.in_valid = 1'b0;
        exp = model_accept(chan, data);
    endtask

    // Waits (bounded) for a result, optionally stalls, compares, then takes it.
    task automatic checkOutput(input string name, input int exp_chan, input longint exp_data,
                               input int hold);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            check($sformatf("%s out_valid timeout", name), 0, 1);
            return;
        end
        repeat (hold) @(negedge clock);
        check($sformatf("%s chan", name), longint'(bus.out_chan), longint'(exp_chan));
        check($sformatf("%s data", name), longint'(bus.out_data), exp_data);
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    task automatic send_and_check(input string name, input int chan, input longint data, input int hold);
        longint e;
        applyStimulus(chan, data, e);
        checkOutput(name, chan, e, hold);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t   vecs [10];
        longint e;
        longint held;
        int     errs;
        logic signed [INW-1:0] r;

        bus.in_valid  = 1'b0;
        bus.in_chan   = '0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        model_clear();

        // Reset values
        repeat (2) @(negedge clock);
        check("reset in_ready",  longint'(bus.in_ready),  1);
        check("reset out_valid", longint'(bus.out_valid), 0);
        check("reset out_data",  longint'(bus.out_data),  0);
        check("reset out_chan",  longint'(bus.out_chan),  0);
        reset = 1'b0;
        @(negedge clock);

        // Table: impulse response with h = 1..5, floor on a negative value,
        // and an out-of-range tag reading channel 0 without storing its sample.
        vecs[0] = '{0, 100, 0, 50};
        vecs[1] = '{0, 0,   0, 100};
        vecs[2] = '{0, 0,   0, 150};
        vecs[3] = '{0, 0,   0, 200};
        vecs[4] = '{0, 0,   0, 250};
        vecs[5] = '{0, 0,   0, 0};
        vecs[6] = '{0, 7,   0, 3};
        vecs[7] = '{3, 999, 3, 3};
        vecs[8] = '{0, 0,   0, 7};
        vecs[9] = '{1, -3,  1, -2};
        set_ramp_coefs();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].chan, vecs[i].data, e);
            checkOutput($sformatf("table[%0d]", i), vecs[i].exp_chan, vecs[i].exp_data, 0);
        end

        // Channel isolation with h = all 1
        set_flat_coefs(1);
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(1, 10, e);
            checkOutput($sformatf("iso ch1[%0d]", i), 1, e, 0);
            applyStimulus(2, -3, e);
            checkOutput($sformatf("iso ch2[%0d]", i), 2, e, 0);
        end
        check("iso ch1 final", m_win[1][TAPS-1] * 0 + model_scale(50), 25);
        send_and_check("iso ch1 steady", 1, 10, 0);
        applyStimulus(2, -3, e);
        checkOutput("iso ch2 steady", 2, -8, 1);

        // Ramp through the circular buffer several times, h = 1..5
        set_ramp_coefs();
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1, i, e);
            if (i == 12) checkOutput("ramp last", 1, 70, 0);
            else         checkOutput($sformatf("ramp[%0d]", i), 1, e, 0);
        end

        // Backpressure: 20 stalled cycles with ignored in_valid pulses
        applyStimulus(0, 1234, e);
        check("mac in_ready", longint'(bus.in_ready), 0);
        for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clock);
        check("bp out_valid", longint'(bus.out_valid), 1);
        held = bus.out_data;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = (i % 3 == 0);
            bus.in_chan  = CW'(2);
            bus.in_data  = INW'(555);
            @(negedge clock);
            if (bus.out_data != OUTW'(held) || bus.in_ready || !bus.out_valid) errs++;
        end
        bus.in_valid = 1'b0;
        check("bp stable errors", errs, 0);
        check("bp data", longint'(bus.out_data), e);
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check("bp released out_valid", longint'(bus.out_valid), 0);
        check("bp released in_ready",  longint'(bus.in_ready), 1);
        errs = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.out_valid) errs++;
        end
        check("bp single transfer", errs, 0);
        send_and_check("bp ch2 untouched", 2, 4, 0);

        // Coefficient write during MAC is dropped
        applyStimulus(0, 100, e);
        bus.coef_we   = 1'b1;
        bus.coef_addr = '0;
        bus.coef_data = INW'(1000);
        repeat (2) @(negedge clock);
        bus.coef_we   = 1'b0;
        checkOutput("mac coef_we", 0, e, 0);
        send_and_check("mac coef_we next", 0, 100, 0);

        // Reset at MAC cycle 3 aborts; history and coefficients are cleared
        applyStimulus(1, 500, e);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort out_valid", longint'(bus.out_valid), 0);
        check("abort in_ready",  longint'(bus.in_ready), 1);
        reset = 1'b0;
        model_clear();
        errs = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.out_valid) errs++;
        end
        check("abort no result", errs, 0);
        set_ramp_coefs();
        applyStimulus(1, 100, e);
        checkOutput("abort impulse0", 1, 50, 0);
        applyStimulus(1, 0, e);
        checkOutput("abort impulse1", 1, 100, 0);

        // Large values: wrap or saturate depending on the build
        set_flat_coefs(32767);
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(2, 32767, e);
            checkOutput($sformatf("big pos[%0d]", i), 2, e, 0);
        end
        applyStimulus(2, 32767, e);
`ifdef FIR_SAT_EN
        checkOutput("big pos steady", 2, 8388607, 0);
`else
        checkOutput("big pos steady", 2, -163838, 0);
`endif
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(2, -32768, e);
            checkOutput($sformatf("big neg[%0d]", i), 2, e, 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            int ch;
            if ($urandom_range(0, 7) == 0) begin
                r = INW'($urandom);
                write_coef(int'($urandom_range(0, TAPS - 1)), longint'(r));
            end
            ch = int'($urandom_range(0, 3));
            r  = INW'($urandom);
            applyStimulus(ch, longint'(r), e);
            checkOutput($sformatf("rand[%0d]", i), ch, e, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
